// File: rtl/percept_pkg.sv
// percept_pkg: shared definitions for the perceptron command path.
//   PKT_BYTES        bytes per command packet (address, opcode, data)
//   ADDR_W           percept address width, also used by percept_bank
//   CLK_PER_BIT_DEF  default UART bit period in clk cycles (50 MHz / 115200)
//   TIMEOUT_BITS_DEF default inter-byte idle allowance in bit periods
//   byte_state_t     UART byte framer states
//   pkt_state_t      packet framer states (which byte is expected next)
package percept_pkg;

  localparam int PKT_BYTES        = 3;
  localparam int ADDR_W           = 8;
  localparam int CLK_PER_BIT_DEF  = 434;
  localparam int TIMEOUT_BITS_DEF = 20;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } byte_state_t;

  typedef enum logic [1:0] {
    P_ADDR,
    P_OP,
    P_DATA
  } pkt_state_t;

  // Next expected byte slot after a good byte; wraps after the last slot.
  function automatic pkt_state_t pkt_advance(input pkt_state_t s);
    case (s)
      P_ADDR:  return P_OP;
      P_OP:    return P_DATA;
      default: return P_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser plus 8N1 byte framer.
//   clk, nRst   system clock, synchronous active-low reset
//   rx          raw serial input (idle high, LSB first)
//   rx_byte     last assembled byte, stable while byte_valid is high
//   byte_valid  one-cycle strobe, cycle after a good stop-bit sample
//   frame_err   one-cycle strobe, cycle after a low stop-bit sample
//   idle        framer is waiting for a start bit
//
// state       | meaning
// B_IDLE      | line idle, waiting for rx_s low
// B_START     | half a bit in, confirming the start bit
// B_DATA      | sampling 8 data bits at bit centres
// B_STOP      | sampling the stop bit
// B_WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module uart_rx_byte
  import percept_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       idle
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLK_PER_BIT - 1);

  logic          rx_m, rx_s;
  byte_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          bv_nxt, fe_nxt;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state      <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      byte_valid <= bv_nxt;
      frame_err  <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    bv_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    case (state)
      B_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = B_START;
      end
      B_START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          // a start bit that has gone high again by mid-bit is a glitch
          state_nxt   = rx_s ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt == FULL_TC) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt == FULL_TC) begin
          cnt_nxt = '0;
          if (rx_s) begin
            bv_nxt    = 1'b1;
            state_nxt = B_IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = B_WAIT_HIGH;
          end
        end
      end
      B_WAIT_HIGH: begin
        // a held-low break must not be taken as a new start bit
        cnt_nxt = '0;
        if (rx_s) state_nxt = B_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = B_IDLE;
      end
    endcase
  end

  assign rx_byte = shreg;
  assign idle    = (state == B_IDLE);

endmodule

// File: rtl/percept_cmd_rx.sv
// percept_cmd_rx: frames UART bytes into 3-byte command packets for the
// perceptron bank and flags framing errors and inter-byte timeouts.
//   clk, nRst   system clock, synchronous active-low reset
//   rx          shared UART serial input
//   cmd_valid   one-cycle strobe, packet on cmd_addr/cmd_op/cmd_data
//   cmd_addr    target percept address (byte 0), held until next packet
//   cmd_op      opcode (byte 1), held until next packet
//   cmd_data    operand (byte 2), held until next packet
//   byte_valid  one-cycle strobe per correctly framed byte
//   frame_err   one-cycle strobe, stop bit sampled low
//   timeout     one-cycle strobe, partial packet abandoned
//
// state  | meaning
// P_ADDR | expecting address byte (no packet in progress)
// P_OP   | address staged, expecting opcode
// P_DATA | address and opcode staged, expecting operand
module percept_cmd_rx
  import percept_pkg::*;
#(
  parameter int CLK_PER_BIT  = CLK_PER_BIT_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              rx,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_op,
  output logic [7:0]        cmd_data,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              timeout
);

  localparam int TO_LIM = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int TW     = $clog2(TO_LIM + 1);
  localparam logic [TW-1:0] TO_TC    = TW'(TO_LIM);
  localparam logic [TW-1:0] TO_TC_M1 = TW'(TO_LIM - 1);

  logic [7:0]        rx_byte;
  logic              bv, fe, idle;
  pkt_state_t        pkt_state, pkt_nxt;
  logic [ADDR_W-1:0] addr_stage, cmd_addr_q;
  logic [7:0]        op_stage, cmd_op_q, cmd_data_q;
  logic [TW-1:0]     to_cnt;
  logic              to_run, to_hit, timeout_q, cmd_fire;

  uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk        (clk),
    .nRst       (nRst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (bv),
    .frame_err  (fe),
    .idle       (idle)
  );

  // Only idle line time inside a packet counts; any byte activity restarts it.
  assign to_run = (pkt_state != P_ADDR) && idle && !bv;
  assign to_hit = to_run && (to_cnt == TO_TC_M1);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (!to_run)              to_cnt <= '0;
      else if (to_cnt != TO_TC) to_cnt <= to_cnt + TW'(1);
    end
  end

  always_comb begin
    pkt_nxt  = pkt_state;
    cmd_fire = 1'b0;
    if (fe) begin
      pkt_nxt = P_ADDR;
    end else if (bv) begin
      pkt_nxt  = pkt_advance(pkt_state);
      cmd_fire = (pkt_state == P_DATA);
    end else if (to_hit) begin
      pkt_nxt = P_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pkt_state  <= P_ADDR;
      addr_stage <= '0;
      op_stage   <= '0;
      cmd_addr_q <= '0;
      cmd_op_q   <= '0;
      cmd_data_q <= '0;
    end else begin
      pkt_state <= pkt_nxt;
      if (bv && pkt_state == P_ADDR) addr_stage <= rx_byte;
      if (bv && pkt_state == P_OP)   op_stage   <= rx_byte;
      if (cmd_fire) begin
        cmd_addr_q <= addr_stage;
        cmd_op_q   <= op_stage;
        cmd_data_q <= rx_byte;
      end
    end
  end

  // Fields are bypassed during the strobe so they are valid in the same
  // cycle as cmd_valid, then held from the registers afterwards.
  assign cmd_valid  = cmd_fire;
  assign cmd_addr   = cmd_fire ? addr_stage : cmd_addr_q;
  assign cmd_op     = cmd_fire ? op_stage   : cmd_op_q;
  assign cmd_data   = cmd_fire ? rx_byte    : cmd_data_q;
  assign byte_valid = bv;
  assign frame_err  = fe;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_percept_cmd_rx.sv
module tb_percept_cmd_rx;

  localparam int CPB = 8;
  localparam int TOB = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx = 1'b1;
  logic       cmd_valid, byte_valid, frame_err, timeout;
  logic [7:0] cmd_addr, cmd_op, cmd_data;

  percept_cmd_rx #(.CLK_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .rx         (rx),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // observed events
  int          n_bv = 0, n_fe = 0, n_to = 0;
  logic [23:0] got_q[$];
  int          last_cmd_cyc = 0;
  logic        prev_cv = 0, prev_bv = 0, prev_fe = 0, prev_to = 0;

  always @(negedge clk) begin
    if (cmd_valid) begin
      got_q.push_back({cmd_addr, cmd_op, cmd_data});
      last_cmd_cyc = cyc;
      check("cmd_valid_with_byte_valid", 32'(byte_valid), 32'd1);
      check("cmd_valid_width", 32'(prev_cv), 32'd0);
    end
    if (byte_valid) begin
      n_bv++;
      check("byte_valid_width", 32'(prev_bv), 32'd0);
    end
    if (frame_err) begin
      n_fe++;
      check("frame_err_width", 32'(prev_fe), 32'd0);
    end
    if (timeout) begin
      n_to++;
      check("timeout_width", 32'(prev_to), 32'd0);
    end
    prev_cv = cmd_valid;
    prev_bv = byte_valid;
    prev_fe = frame_err;
    prev_to = timeout;
  end

  // reference model: packet framing by byte list, gap length and stop-bit quality
  int          m_n = 0;
  logic [7:0]  m_stage[3];
  int          exp_bv = 0, exp_fe = 0, exp_to = 0;
  logic [23:0] exp_q[$];
  int          chk_idx = 0;
  int          stop_cyc = 0;

  task automatic model_byte(input logic [7:0] b, input bit bad, input int gap);
    // gaps used are either far below or far above the timeout window
    if (gap >= TOB * CPB && m_n > 0) begin
      exp_to++;
      m_n = 0;
    end
    if (bad) begin
      exp_fe++;
      m_n = 0;
    end else begin
      exp_bv++;
      m_stage[m_n] = b;
      m_n++;
      if (m_n == 3) begin
        exp_q.push_back({m_stage[0], m_stage[1], m_stage[2]});
        m_n = 0;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      rx = 1'b1;
      repeat (n - 1) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    @(negedge clk);
    stop_cyc = cyc;
    rx = ~bad;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input int gap);
    model_byte(b, bad, gap);
    idle(gap);
    send_byte(b, bad);
  endtask

  task automatic finish_idle();
    idle(60);
    if (m_n > 0) begin
      exp_to++;
      m_n = 0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nRst = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    check({tag, "_cmd_valid"},  32'(cmd_valid),  32'd0);
    check({tag, "_cmd_addr"},   32'(cmd_addr),   32'd0);
    check({tag, "_cmd_op"},     32'(cmd_op),     32'd0);
    check({tag, "_cmd_data"},   32'(cmd_data),   32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_frame_err"},  32'(frame_err),  32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
    nRst = 1'b1;
    m_n  = 0;
  endtask

  task automatic phase_check(input string tag);
    check({tag, "_byte_valid_count"}, 32'(n_bv), 32'(exp_bv));
    check({tag, "_frame_err_count"},  32'(n_fe), 32'(exp_fe));
    check({tag, "_timeout_count"},    32'(n_to), 32'(exp_to));
    check({tag, "_packet_count"},     32'(got_q.size()), 32'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_packet"}, 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_q.size() > 0)
      check({tag, "_held_fields"}, 32'({cmd_addr, cmd_op, cmd_data}), 32'(exp_q[exp_q.size()-1]));
    chk_idx = exp_q.size();
  endtask

  initial begin
    logic [7:0] rb;
    bit         rbad, prev_bad;
    int         rgap;

    repeat (3) @(negedge clk);
    do_reset("reset");
    idle(10);

    // basic packet and strobe latency
    send(8'h05, 1'b0, 0);
    send(8'h12, 1'b0, 0);
    send(8'hA7, 1'b0, 0);
    idle(2);
    check("cmd_latency", 32'(last_cmd_cyc - stop_cyc), 32'(CPB / 2 + 3));
    finish_idle();
    phase_check("basic");

    // inter-byte timeout
    send(8'h05, 1'b0, 2);
    send(8'h12, 1'b0, 0);
    send(8'hFF, 1'b0, 40);
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b0, 0);
    finish_idle();
    phase_check("timeout");

    // framing error on a lone byte
    send(8'h10, 1'b1, 2);
    send(8'h20, 1'b0, 8);
    send(8'h30, 1'b0, 0);
    send(8'h40, 1'b0, 0);
    finish_idle();
    phase_check("frame_err");

    // short start glitch
    idle(5);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    idle(20);
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b0, 0);
    send(8'h03, 1'b0, 0);
    finish_idle();
    phase_check("glitch");

    // line break
    idle(5);
    @(negedge clk);
    rx = 1'b0;
    repeat (199) @(negedge clk);
    exp_fe++;
    m_n = 0;
    send(8'hAA, 1'b0, 10);
    send(8'h55, 1'b0, 0);
    send(8'h0F, 1'b0, 0);
    finish_idle();
    phase_check("break");

    // reset in the middle of the second byte of a packet
    send(8'h77, 1'b0, 5);
    idle(4);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    do_reset("midreset");
    idle(30);
    send(8'h03, 1'b0, 0);
    send(8'h04, 1'b0, 0);
    send(8'h05, 1'b0, 0);
    finish_idle();
    phase_check("midreset");

    // randomized byte stream
    prev_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 7) == 0);
      if (prev_bad)                     rgap = $urandom_range(6, 10);
      else if ($urandom_range(0, 5) == 0) rgap = $urandom_range(40, 60);
      else                              rgap = $urandom_range(0, 8);
      send(rb, rbad, rgap);
      prev_bad = rbad;
    end
    finish_idle();
    phase_check("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
